// File: rtl/clk_meter_pkg.sv
// Shared definitions for the clock ratio meter.
//   state_t    : measurement FSM states
//   CNT_W      : width of the rise-to-rise cycle counter
//   PERIOD_MAX : largest period that can be reported; reaching it without a
//                rise is a timeout
//   VAL_W      : width of the reported period / high_time values
package clk_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam int CNT_W      = 5;
    localparam int PERIOD_MAX = 15;
    localparam int VAL_W      = 4;

endpackage

// File: rtl/clock_ratio_meter_if.sv
// Signal bundle between a stimulus source and the clock ratio meter.
//   enable    : high = measure, low = hold the meter idle
//   sig_in    : divided clock waveform, synchronous to the system clock
//   period    : last measured rise-to-rise period in clock cycles
//   high_time : high cycles within that period
//   valid     : one-cycle pulse, period/high_time updated
//   locked    : level, the last measurements were identical
//   timeout   : one-cycle pulse, no rise seen for 16 cycles
// master drives enable/sig_in; slave (the meter) drives the results.
interface clock_ratio_meter_if;
    import clk_meter_pkg::*;

    logic             enable;
    logic             sig_in;
    logic [VAL_W-1:0] period;
    logic [VAL_W-1:0] high_time;
    logic             valid;
    logic             locked;
    logic             timeout;

    modport master (
        output enable, sig_in,
        input  period, high_time, valid, locked, timeout
    );

    modport slave (
        input  enable, sig_in,
        output period, high_time, valid, locked, timeout
    );

endinterface

// File: rtl/clock_ratio_meter_edge_detect.sv
// Edge detector for a waveform already synchronous to clk_in.
//   clk_in : system clock
//   rst_n  : synchronous active-low reset
//   sig_in : input waveform
//   rise   : sig_in high now, low on the previous cycle
//   fall   : sig_in low now, high on the previous cycle
module edge_detect (
    input  logic clk_in,
    input  logic rst_n,
    input  logic sig_in,
    output logic rise,
    output logic fall
);

    logic s_q;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            s_q <= 1'b0;
        end else begin
            s_q <= sig_in;
        end
    end

    assign rise = sig_in & ~s_q;
    assign fall = ~sig_in & s_q;

endmodule

// File: rtl/clock_ratio_meter.sv
// Measures the period and high time of a divided clock in system clock
// cycles and reports lock once LOCK_COUNT consecutive measurements agree.
//   clk_in : system clock
//   rst_n  : synchronous active-low reset
//   bus    : slave side of clock_ratio_meter_if (enable, sig_in in;
//            period, high_time, valid, locked, timeout out)
// LOCK_COUNT : consecutive identical measurements needed for lock (2..3)
module clock_ratio_meter
    import clk_meter_pkg::*;
#(
    parameter int LOCK_COUNT = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    clock_ratio_meter_if.slave   bus
);

    localparam logic [1:0] MATCH_MAX = 2'(LOCK_COUNT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [VAL_W-1:0] hi_cnt;
    logic [1:0]       match_cnt;
    logic             ref_vld;      // period_q/high_q hold a comparable measurement
    logic [VAL_W-1:0] period_q;
    logic [VAL_W-1:0] high_q;
    logic             valid_q;
    logic             locked_q;
    logic             timeout_q;

    logic             rise;
    logic             unused_fall;
    logic [1:0]       match_inc;
    logic             same_meas;

    edge_detect u_edge (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .sig_in (bus.sig_in),
        .rise   (rise),
        .fall   (unused_fall)
    );

    // Saturating next match count and comparison against the last result.
    always_comb begin
        match_inc = match_cnt;
        if (match_cnt != MATCH_MAX) begin
            match_inc = match_cnt + 2'd1;
        end
        same_meas = ref_vld && ({cnt[VAL_W-1:0], hi_cnt} == {period_q, high_q});
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            hi_cnt    <= '0;
            match_cnt <= '0;
            ref_vld   <= 1'b0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            if (!bus.enable) begin
                // period_q/high_q deliberately keep the last result
                state     <= IDLE;
                cnt       <= '0;
                hi_cnt    <= '0;
                match_cnt <= '0;
                ref_vld   <= 1'b0;
                locked_q  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= ARM;
                    end
                    ARM, MEASURE: begin
                        if (rise) begin
                            // a rise on the cnt==PERIOD_MAX cycle still reports
                            cnt    <= CNT_W'(1);
                            hi_cnt <= VAL_W'(1);
                            if (state == ARM) begin
                                state <= MEASURE;
                            end else begin
                                period_q <= cnt[VAL_W-1:0];
                                high_q   <= hi_cnt;
                                valid_q  <= 1'b1;
                                ref_vld  <= 1'b1;
                                if (same_meas) begin
                                    match_cnt <= match_inc;
                                    locked_q  <= (match_inc == MATCH_MAX);
                                end else begin
                                    match_cnt <= '0;
                                    locked_q  <= 1'b0;
                                end
                            end
                        end else if (cnt == CNT_W'(PERIOD_MAX)) begin
                            timeout_q <= 1'b1;
                            cnt       <= '0;
                            hi_cnt    <= '0;
                            match_cnt <= '0;
                            ref_vld   <= 1'b0;
                            locked_q  <= 1'b0;
                            state     <= ARM;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                            if (bus.sig_in && (hi_cnt != VAL_W'(PERIOD_MAX))) begin
                                hi_cnt <= hi_cnt + VAL_W'(1);
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.period    = period_q;
    assign bus.high_time = high_q;
    assign bus.valid     = valid_q;
    assign bus.locked    = locked_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_clock_ratio_meter.sv
// Bench for clock_ratio_meter: directed waveforms, a timestamp/window based
// reference model compared every cycle, and hand-computed literal checks.
module tb_clock_ratio_meter;

    localparam int LOCK_COUNT = 2;

    logic clk;
    logic rst_n;

    clock_ratio_meter_if bus ();

    clock_ratio_meter #(.LOCK_COUNT(LOCK_COUNT)) dut (
        .clk_in (clk),
        .rst_n  (rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int npass  = 0;
    int ntotal = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) begin
            npass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phases: 0 idle, 1 armed, 2 measuring. 'origin' is the cycle index where
    // the current count window started; the elapsed count is cyc - origin.
    int  m_phase, m_per, m_hi, m_val, m_lock, m_to;
    int  cyc, origin;
    bit  m_sq;
    bit  model_on = 1'b0;
    bit  win[$];          // sig_in samples since the last rise
    int  hist[$];         // recent measurements as {period, high_time}

    always @(posedge clk) begin
        bit rise;
        int ones;
        if (!rst_n) begin
            m_phase = 0; m_sq = 1'b0; m_per = 0; m_hi = 0;
            m_val = 0; m_lock = 0; m_to = 0;
            cyc = 0; origin = 0;
            win.delete(); hist.delete();
            model_on = 1'b1;
        end else begin
            rise  = bus.sig_in && !m_sq;
            m_val = 0;
            m_to  = 0;
            if (!bus.enable) begin
                m_phase = 0;
                m_lock  = 0;
                hist.delete();
            end else if (m_phase == 0) begin
                m_phase = 1;
                origin  = cyc + 1;
            end else if (rise) begin
                if (m_phase == 2) begin
                    m_per = cyc - origin;
                    ones  = 0;
                    foreach (win[k]) ones += int'(win[k]);
                    m_hi  = (ones > 15) ? 15 : ones;
                    m_val = 1;
                    hist.push_back(m_per * 16 + m_hi);
                    while (hist.size() > LOCK_COUNT) void'(hist.pop_front());
                    m_lock = (hist.size() == LOCK_COUNT) ? 1 : 0;
                    foreach (hist[k]) if (hist[k] != hist[0]) m_lock = 0;
                end
                m_phase = 2;
                origin  = cyc;
                win.delete();
            end else if (cyc - origin == 15) begin
                m_to   = 1;
                origin = cyc + 1;
                if (m_phase == 2) begin
                    m_phase = 1;
                    m_lock  = 0;
                    hist.delete();
                end
            end
            win.push_back(bus.sig_in);
            m_sq = bus.sig_in;
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("valid",     bus.valid,     m_val);
            chk("timeout",   bus.timeout,   m_to);
            chk("locked",    bus.locked,    m_lock);
            chk("period",    bus.period,    m_per);
            chk("high_time", bus.high_time, m_hi);
        end
    end

    // ---------------- stimulus and event log ----------------
    typedef struct { int p; int h; int l; } vrec_t;
    vrec_t vq[$];
    int    toq[$];
    int    tidx;

    task automatic clear_log();
        vq.delete();
        toq.delete();
        tidx = 0;
    endtask

    // Drive one cycle of sig_in and log the outputs produced by that edge.
    task automatic tick(input bit s);
        bus.sig_in = s;
        @(negedge clk);
        if (bus.valid === 1'b1)
            vq.push_back('{int'(bus.period), int'(bus.high_time), int'(bus.locked)});
        if (bus.timeout === 1'b1)
            toq.push_back(tidx);
        tidx++;
    endtask

    // pat is consumed LSB first.
    task automatic play(input logic [15:0] pat, input int len, input int reps);
        for (int i = 0; i < len * reps; i++) tick(pat[i % len]);
    endtask

    task automatic go_idle();
        bus.enable = 1'b0;
        tick(1'b0);
        tick(1'b0);
        bus.enable = 1'b1;
        clear_log();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        bus.enable = 1'b0;
        bus.sig_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_period", bus.period, 0);
        chk("rst_high",   bus.high_time, 0);
        chk("rst_locked", bus.locked, 0);
        chk("rst_valid",  bus.valid, 0);

        // 0,1,0 repeating: 3/1, lock on second valid
        rst_n = 1'b1;
        bus.enable = 1'b1;
        clear_log();
        play(16'b010, 3, 5);
        chk("A_nvalid", vq.size(), 4);
        chk("A_v0_period", vq[0].p, 3);
        chk("A_v0_high",   vq[0].h, 1);
        chk("A_v0_locked", vq[0].l, 0);
        chk("A_v1_locked", vq[1].l, 1);

        // enable low while locked: cleared status, held results
        bus.enable = 1'b0;
        tick(1'b0);
        chk("idle_locked", bus.locked, 0);
        chk("idle_period", bus.period, 3);
        chk("idle_high",   bus.high_time, 1);
        tick(1'b0);
        bus.enable = 1'b1;
        clear_log();

        // 4 low / 4 high: 8/4, first rise only arms
        play(16'b1111_0000, 8, 4);
        chk("B_nvalid", vq.size(), 3);
        chk("B_v0_period", vq[0].p, 8);
        chk("B_v0_high",   vq[0].h, 4);
        chk("B_v0_locked", vq[0].l, 0);
        chk("B_v1_locked", vq[1].l, 1);

        // switch from locked period 8 to 1,0,0 (period 3)
        clear_log();
        play(16'b001, 3, 4);
        chk("C_nvalid", vq.size(), 3);
        chk("C_v0_period", vq[0].p, 7);
        chk("C_v0_high",   vq[0].h, 5);
        chk("C_v0_locked", vq[0].l, 0);
        chk("C_v1_period", vq[1].p, 3);
        chk("C_v1_high",   vq[1].h, 1);
        chk("C_v1_locked", vq[1].l, 0);
        chk("C_v2_locked", vq[2].l, 1);

        // constant low: timeouts 16 cycles apart, no valid
        go_idle();
        repeat (40) tick(1'b0);
        chk("D_ntimeout", toq.size(), 2);
        chk("D_to0", toq[0], 16);
        chk("D_to1", toq[1], 32);
        chk("D_nvalid", vq.size(), 0);

        // period exactly 15 reports; gap of 16 times out instead
        go_idle();
        for (int i = 0; i < 56; i++) tick(i == 1 || i == 16 || i == 31 || i == 47);
        chk("E_nvalid", vq.size(), 2);
        chk("E_v0_period", vq[0].p, 15);
        chk("E_v0_high",   vq[0].h, 1);
        chk("E_v1_locked", vq[1].l, 1);
        chk("E_ntimeout", toq.size(), 1);
        chk("E_to0", toq[0], 46);

        // lock again, then reset in the middle of a period
        clear_log();
        play(16'b010, 3, 4);
        chk("F_v0_period", vq[0].p, 10);
        chk("F_v2_locked", vq[2].l, 1);
        rst_n = 1'b0;
        tick(1'b0);
        chk("F_rst_period", bus.period, 0);
        chk("F_rst_high",   bus.high_time, 0);
        chk("F_rst_locked", bus.locked, 0);
        rst_n = 1'b1;
        clear_log();
        play(16'b010, 3, 6);
        chk("F_nvalid", vq.size(), 5);
        chk("F_v0_period", vq[0].p, 3);
        chk("F_v0_locked", vq[0].l, 0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
